// File: rtl/pwm_motor_if.sv
// -----------------------------------------------------------------------------
// pwm_motor_if
// Command and status bundle for the multi-channel PWM motor driver.
//
// Signals:
//   cmd           packed per-channel commands, channel i at [i*CMD_W +: CMD_W];
//                 MSB = direction (1 = reverse), low CMD_W-1 bits = magnitude
//   cmd_valid     per-channel load strobe
//   estop         level-sensitive emergency stop
//   spd           per-channel PWM speed output
//   dir           per-channel direction output
//   busy          per-channel "not yet settled at target"
//   period_start  one-clk pulse on the first clk of each PWM period
//
// Modports:
//   master  drives commands, observes status (controller / testbench side)
//   slave   the driver itself
// -----------------------------------------------------------------------------
interface pwm_motor_if #(
  parameter int CHANNELS = 2,
  parameter int CMD_W    = 4
);
  logic [CHANNELS*CMD_W-1:0] cmd;
  logic [CHANNELS-1:0]       cmd_valid;
  logic                      estop;
  logic [CHANNELS-1:0]       spd;
  logic [CHANNELS-1:0]       dir;
  logic [CHANNELS-1:0]       busy;
  logic                      period_start;

  modport master (
    output cmd, cmd_valid, estop,
    input  spd, dir, busy, period_start
  );

  modport slave (
    input  cmd, cmd_valid, estop,
    output spd, dir, busy, period_start
  );
endinterface

// File: rtl/pwm_motor_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_motor_ctrl
// Multi-channel PWM motor driver. Each channel turns a signed speed command
// (direction bit + magnitude) into a glitch-free PWM speed output and a
// direction output. Duty ramps by one LSB per step strobe; a direction change
// ramps the duty down to zero, holds a dead time with the output forced low,
// flips direction and ramps back up. estop drops every channel to duty 0
// immediately without any reversal.
//
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  pwm_motor_if.slave: cmd / cmd_valid / estop in,
//        spd / dir / busy / period_start out
//
// Timebase (shared by all channels):
//   prescaler 0..PRESCALE-1 -> tick; PWM counter cnt 0..MAX-1 advances on tick,
//   so a period is MAX ticks. The tick on which cnt wraps is the period
//   boundary; every RAMP_PERIODS-th boundary is a step.
// -----------------------------------------------------------------------------
module pwm_motor_ctrl #(
  parameter int CHANNELS     = 2,
  parameter int CMD_W        = 4,
  parameter int PRESCALE     = 100,
  parameter int RAMP_PERIODS = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic         clk,
  input  logic         rst,
  pwm_motor_if.slave   bus
);

  localparam int M   = CMD_W - 1;
  localparam int MAX = (1 << M) - 1;
  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RW  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int DW  = $clog2(DEAD_PERIODS + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DOWN = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  typedef struct packed {
    state_e         state;
    logic [M-1:0]   duty;
    logic [M-1:0]   target_mag;
    logic           target_dir;
    logic           cur_dir;
    logic [DW-1:0]  dead_cnt;
  } chan_t;

  // ---------------------------------------------------------------------------
  // Shared timebase
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [M-1:0]  cnt_q;
  logic [RW-1:0] pcnt_q;
  logic          period_start_q;

  logic tick;
  logic wrap;
  logic boundary;
  logic step;

  assign tick     = (presc_q == PW'(PRESCALE - 1));
  assign wrap     = (cnt_q == M'(MAX - 1));
  assign boundary = tick && wrap;
  assign step     = boundary && (pcnt_q == RW'(RAMP_PERIODS - 1));

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      pcnt_q         <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      end
      if (boundary) begin
        pcnt_q <= (pcnt_q == RW'(RAMP_PERIODS - 1)) ? '0 : pcnt_q + 1'b1;
      end
      period_start_q <= boundary;
    end
  end

  assign bus.period_start = period_start_q;

  // ---------------------------------------------------------------------------
  // Per-channel state
  // ---------------------------------------------------------------------------
  chan_t               ch_q [CHANNELS];
  chan_t               ch_d [CHANNELS];
  logic [CHANNELS-1:0] spd_q;
  logic [CHANNELS-1:0] spd_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_q[i] <= '0;
      end
      spd_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_q[i] <= ch_d[i];
      end
      spd_q <= spd_d;
    end
  end

  // Next-state logic. Duty only ever changes on a step (which is also a
  // boundary), i.e. together with cnt wrapping to 0, so every period runs
  // with a single duty value and no pulse is cut short or stretched.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      // NOTE: hold every field by default before any branch so that no path
      // through this block leaves a variable unassigned (no latches).
      ch_d[i]  = ch_q[i];
      spd_d[i] = 1'b0;

      if (bus.estop) begin
        // Emergency stop: drop to zero in place, cancel any pending reversal,
        // and ignore commands. The timebase is left running.
        ch_d[i].state      = ST_RUN;
        ch_d[i].duty       = '0;
        ch_d[i].target_mag = '0;
        ch_d[i].target_dir = ch_q[i].cur_dir;
        ch_d[i].dead_cnt   = '0;
      end else begin
        if (bus.cmd_valid[i]) begin
          ch_d[i].target_dir = bus.cmd[i*CMD_W + M];
          ch_d[i].target_mag = bus.cmd[i*CMD_W +: M];
        end

        // cnt ranges 0..MAX-1, so duty 0 never drives high and duty MAX
        // never drives low -- no one-clk glitch at the wrap.
        spd_d[i] = (ch_q[i].state != ST_DEAD) && (cnt_q < ch_q[i].duty);

        unique case (ch_q[i].state)
          ST_RUN: begin
            if (ch_q[i].target_dir != ch_q[i].cur_dir) begin
              ch_d[i].state = ST_DOWN;
            end else if (step) begin
              if (ch_q[i].duty < ch_q[i].target_mag) begin
                ch_d[i].duty = ch_q[i].duty + 1'b1;
              end else if (ch_q[i].duty > ch_q[i].target_mag) begin
                ch_d[i].duty = ch_q[i].duty - 1'b1;
              end
            end
          end

          ST_DOWN: begin
            // Already at zero: enter dead time straight away. Otherwise the
            // step that takes duty to zero is also the dead-time entry.
            if (ch_q[i].duty == '0) begin
              ch_d[i].state    = ST_DEAD;
              ch_d[i].dead_cnt = '0;
            end else if (step) begin
              ch_d[i].duty = ch_q[i].duty - 1'b1;
              if (ch_q[i].duty == M'(1)) begin
                ch_d[i].state    = ST_DEAD;
                ch_d[i].dead_cnt = '0;
              end
            end
          end

          ST_DEAD: begin
            if (boundary) begin
              ch_d[i].dead_cnt = ch_q[i].dead_cnt + 1'b1;
              if (ch_q[i].dead_cnt == DW'(DEAD_PERIODS - 1)) begin
                // Adopt the most recent direction, including one loaded on
                // this very cycle.
                ch_d[i].cur_dir = ch_d[i].target_dir;
                ch_d[i].state   = ST_RUN;
              end
            end
          end

          default: begin
            ch_d[i].state = ST_RUN;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.spd = spd_q;

  // dir is the registered cur_dir; it is held through DOWN and DEAD and only
  // changes on the boundary that ends the dead time.
  always_comb begin
    bus.dir  = '0;
    bus.busy = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.dir[i]  = ch_q[i].cur_dir;
      bus.busy[i] = (ch_q[i].state != ST_RUN) ||
                    (ch_q[i].duty != ch_q[i].target_mag) ||
                    (ch_q[i].target_dir != ch_q[i].cur_dir);
    end
  end

endmodule

// File: tb/tb_pwm_motor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_motor_ctrl
// Scoreboard bench for pwm_motor_ctrl with PRESCALE=2, RAMP_PERIODS=1,
// DEAD_PERIODS=2, CMD_W=4 (MAX=7, one PWM period = 14 clks).
// Each expected period is (ch0 high clks, ch1 high clks, dir, busy), with dir
// and busy taken at the first clk of that period. Expectations are pushed when
// a command is issued; the monitor pops one per completed period.
// -----------------------------------------------------------------------------
module tb_pwm_motor_ctrl;

  localparam int CH  = 2;
  localparam int CW  = 4;
  localparam int PRE = 2;
  localparam int PER = PRE * 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pwm_motor_if #(.CHANNELS(CH), .CMD_W(CW)) bus ();

  pwm_motor_ctrl #(
    .CHANNELS    (CH),
    .CMD_W       (CW),
    .PRESCALE    (PRE),
    .RAMP_PERIODS(1),
    .DEAD_PERIODS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         h0;
    int         h1;
    logic [1:0] dir;
    logic [1:0] busy;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_period = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Period monitor
  // ---------------------------------------------------------------------------
  int         acc0;
  int         acc1;
  logic       started;
  logic [1:0] st_dir;
  logic [1:0] st_busy;
  exp_t       e;

  always @(negedge clk) begin
    if (!rst) begin
      started = 1'b0;
      acc0    = 0;
      acc1    = 0;
    end else begin
      acc0 += int'(bus.spd[0]);
      acc1 += int'(bus.spd[1]);
      if (bus.period_start) begin
        if (started && sb.size() > 0) begin
          e = sb.pop_front();
          n_period++;
          check($sformatf("p%0d_h0", n_period), acc0, e.h0);
          check($sformatf("p%0d_h1", n_period), acc1, e.h1);
          check($sformatf("p%0d_dir", n_period), st_dir, e.dir);
          check($sformatf("p%0d_busy", n_period), st_busy, e.busy);
        end
        started = 1'b1;
        st_dir  = bus.dir;
        st_busy = bus.busy;
        acc0    = 0;
        acc1    = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push(input int h0, input int h1, input logic [1:0] d, input logic [1:0] b);
    exp_t x;
    x.h0   = h0;
    x.h1   = h1;
    x.dir  = d;
    x.busy = b;
    sb.push_back(x);
  endtask

  // Returns 1 ns after the negedge at which period_start is seen.
  task automatic wait_period_start();
    int k = 0;
    @(negedge clk);
    while (!bus.period_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("sync_period_start", bus.period_start, 1);
    #1;
  endtask

  task automatic load(input logic [1:0] v, input logic [3:0] c0, input logic [3:0] c1);
    bus.cmd       = {c1, c0};
    bus.cmd_valid = v;
    @(negedge clk);
    #1;
    bus.cmd_valid = '0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Releases reset on a negedge and counts clks to the first period_start,
  // also confirming spd stays low meanwhile.
  task automatic release_and_time(input string tag);
    int   k    = 0;
    logic seen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do begin
      @(negedge clk);
      k++;
      seen |= |bus.spd;
    end while (!bus.period_start && k < 40);
    check({tag, "_first_period_start"}, k, PER);
    check({tag, "_spd_quiet"}, seen, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int   hi;
    logic bsy;

    bus.cmd       = '0;
    bus.cmd_valid = '0;
    bus.estop     = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_spd", bus.spd, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_period_start", bus.period_start, 0);
    release_and_time("init");

    // Ramp up ch0 to 5 forward; ch1 idle
    wait_period_start();
    push(0, 0, 2'b00, 2'b00);
    push(2, 0, 2'b00, 2'b01);
    push(4, 0, 2'b00, 2'b01);
    push(6, 0, 2'b00, 2'b01);
    push(8, 0, 2'b00, 2'b01);
    push(10, 0, 2'b00, 2'b00);
    push(10, 0, 2'b00, 2'b00);
    load(2'b01, 4'b0101, 4'b0000);
    drain();

    // ch0 to full scale, ch1 to 2, independently
    wait_period_start();
    push(10, 0, 2'b00, 2'b00);
    push(12, 2, 2'b00, 2'b11);
    push(14, 4, 2'b00, 2'b00);
    push(14, 4, 2'b00, 2'b00);
    load(2'b11, 4'b0111, 4'b0010);
    drain();

    // ch1 back to zero, ch0 stays at full scale
    wait_period_start();
    push(14, 4, 2'b00, 2'b00);
    push(14, 2, 2'b00, 2'b10);
    push(14, 0, 2'b00, 2'b00);
    push(14, 0, 2'b00, 2'b00);
    load(2'b10, 4'b0111, 4'b0000);
    drain();

    // ch0 down to 3 forward
    wait_period_start();
    push(14, 0, 2'b00, 2'b00);
    push(12, 0, 2'b00, 2'b01);
    push(10, 0, 2'b00, 2'b01);
    push(8, 0, 2'b00, 2'b01);
    push(6, 0, 2'b00, 2'b00);
    push(6, 0, 2'b00, 2'b00);
    load(2'b01, 4'b0011, 4'b0000);
    drain();

    // Reversal to 3 reverse: 2,1, two dead periods, dir flips, 1,2,3
    wait_period_start();
    push(6, 0, 2'b00, 2'b00);
    push(4, 0, 2'b00, 2'b01);
    push(2, 0, 2'b00, 2'b01);
    push(0, 0, 2'b00, 2'b01);
    push(0, 0, 2'b00, 2'b01);
    push(0, 0, 2'b01, 2'b01);
    push(2, 0, 2'b01, 2'b01);
    push(4, 0, 2'b01, 2'b01);
    push(6, 0, 2'b01, 2'b00);
    push(6, 0, 2'b01, 2'b00);
    load(2'b01, 4'b1011, 4'b0000);
    drain();

    // Mid-period command at cnt = 3: current period keeps its high time
    wait_period_start();
    repeat (6) @(negedge clk);
    #1;
    push(6, 0, 2'b01, 2'b00);
    push(8, 0, 2'b01, 2'b01);
    push(10, 0, 2'b01, 2'b00);
    push(10, 0, 2'b01, 2'b00);
    load(2'b01, 4'b1101, 4'b0000);
    drain();

    // Reversal 5 reverse -> 5 forward
    wait_period_start();
    push(10, 0, 2'b01, 2'b00);
    push(8, 0, 2'b01, 2'b01);
    push(6, 0, 2'b01, 2'b01);
    push(4, 0, 2'b01, 2'b01);
    push(2, 0, 2'b01, 2'b01);
    push(0, 0, 2'b01, 2'b01);
    push(0, 0, 2'b01, 2'b01);
    push(0, 0, 2'b00, 2'b01);
    push(2, 0, 2'b00, 2'b01);
    push(4, 0, 2'b00, 2'b01);
    push(6, 0, 2'b00, 2'b01);
    push(8, 0, 2'b00, 2'b01);
    push(10, 0, 2'b00, 2'b00);
    push(10, 0, 2'b00, 2'b00);
    load(2'b01, 4'b0101, 4'b0000);
    drain();

    // estop at duty 5 forward, inside the high part of the period
    wait_period_start();
    repeat (3) @(negedge clk);
    check("pre_estop_spd0", bus.spd[0], 1);
    #1;
    bus.estop = 1'b1;
    @(negedge clk);
    check("estop_spd", bus.spd, 0);
    check("estop_busy", bus.busy, 0);
    check("estop_dir", bus.dir, 0);
    #1;
    load(2'b01, 4'b1111, 4'b0000);
    hi  = 0;
    bsy = 1'b0;
    repeat (30) begin
      @(negedge clk);
      hi  += int'(|bus.spd);
      bsy |= |bus.busy;
    end
    check("estop_spd_held", hi, 0);
    check("estop_cmd_ignored_busy", bsy, 0);
    check("estop_dir_held", bus.dir, 0);
    #1;
    bus.estop = 1'b0;

    // After estop: ramp from 0, dir unchanged, no dead time
    wait_period_start();
    push(0, 0, 2'b00, 2'b00);
    push(2, 0, 2'b00, 2'b01);
    push(4, 0, 2'b00, 2'b00);
    push(4, 0, 2'b00, 2'b00);
    load(2'b01, 4'b0010, 4'b0000);
    drain();

    // Back up to 5, then reset mid-PWM
    wait_period_start();
    push(4, 0, 2'b00, 2'b00);
    push(6, 0, 2'b00, 2'b01);
    push(8, 0, 2'b00, 2'b01);
    push(10, 0, 2'b00, 2'b00);
    load(2'b01, 4'b0101, 4'b0000);
    drain();

    wait_period_start();
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_spd", bus.spd, 0);
    check("midrst_dir", bus.dir, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_period_start", bus.period_start, 0);
    release_and_time("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
